// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory address select and
// a two-state IF/ID assembler for one- and two-byte instructions.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   pc_en, pc_load    PC update enable; load (else increment) when enabled
//   pc_src            load source: 00 r_rb_ex, 01 imem_rdata, 10 r_rb_d, 11 stack_data
//   addr_src          imem address: 00/11 PC, 01 reset vector 0, 10 interrupt vector 1
//   stall             freezes the IF/ID register and the assembler FSM
//   r_rb_ex, r_rb_d, stack_data   branch / jump / return targets
//   imem_rdata        combinational read data for imem_addr
//   imem_addr         combinational instruction-memory address
//   pc                current PC
//   ifid_valid, ifid_instr, ifid_imm, ifid_pc   IF/ID register contents
module fetch_stage #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pc_en,
    input  logic          pc_load,
    input  logic [1:0]    pc_src,
    input  logic [1:0]    addr_src,
    input  logic          stall,
    input  logic [AW-1:0] r_rb_ex,
    input  logic [AW-1:0] r_rb_d,
    input  logic [AW-1:0] stack_data,
    input  logic [DW-1:0] imem_rdata,
    output logic [AW-1:0] imem_addr,
    output logic [AW-1:0] pc,
    output logic          ifid_valid,
    output logic [DW-1:0] ifid_instr,
    output logic [DW-1:0] ifid_imm,
    output logic [AW-1:0] ifid_pc
);

    localparam int unsigned OPW        = 4;
    localparam logic [OPW-1:0] OP_WIDE = 4'd12;

    typedef enum logic [0:0] {
        F_OP  = 1'b0,
        F_IMM = 1'b1
    } fstate_e;

    fstate_e       state_q, state_d;
    logic [AW-1:0] pc_d;
    logic          valid_d;
    logic [DW-1:0] instr_d, imm_d;
    logic [AW-1:0] ipc_d;
    logic          flush;
    logic          vector_fetch;

    // A PC load redirects the stream, so whatever was being assembled is dead.
    assign flush        = pc_en & pc_load;
    assign vector_fetch = (addr_src == 2'b01) || (addr_src == 2'b10);

    // Instruction-memory address select
    always_comb begin
        unique case (addr_src)
            2'b01:   imem_addr = '0;
            2'b10:   imem_addr = AW'(1);
            default: imem_addr = pc;
        endcase
    end

    // Next PC: load from selected source or increment (wraps naturally)
    always_comb begin
        pc_d = pc;
        if (pc_en) begin
            if (pc_load) begin
                unique case (pc_src)
                    2'b00:   pc_d = r_rb_ex;
                    2'b01:   pc_d = AW'(imem_rdata);
                    2'b10:   pc_d = r_rb_d;
                    default: pc_d = stack_data;
                endcase
            end else begin
                pc_d = pc + AW'(1);
            end
        end
    end

    // Assembler next state and IF/ID next values; flush beats stall beats capture
    always_comb begin
        state_d = state_q;
        valid_d = ifid_valid;
        instr_d = ifid_instr;
        imm_d   = ifid_imm;
        ipc_d   = ifid_pc;
        if (flush) begin
            state_d = F_OP;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (vector_fetch) begin
                // The byte read from a vector slot is an address, not an instruction.
                state_d = F_OP;
                valid_d = 1'b0;
            end else begin
                unique case (state_q)
                    F_OP: begin
                        instr_d = imem_rdata;
                        ipc_d   = pc;
                        imm_d   = '0;
                        if (imem_rdata[DW-1 -: OPW] == OP_WIDE) begin
                            valid_d = 1'b0;
                            state_d = F_IMM;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end
                    F_IMM: begin
                        imm_d   = imem_rdata;
                        valid_d = 1'b1;
                        state_d = F_OP;
                    end
                    default: state_d = F_OP;
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= F_OP;
            pc         <= '0;
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_imm   <= '0;
            ifid_pc    <= '0;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            ifid_valid <= valid_d;
            ifid_instr <= instr_d;
            ifid_imm   <= imm_d;
            ifid_pc    <= ipc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes per-edge expectations into a
// queue, a monitor pops and compares them after each rising edge.
module tb_fetch_stage;

    logic       clk;
    logic       reset;
    logic       pc_en, pc_load, stall;
    logic [1:0] pc_src, addr_src;
    logic [7:0] r_rb_ex, r_rb_d, stack_data;
    logic [7:0] imem_rdata, imem_addr, pc;
    logic       ifid_valid;
    logic [7:0] ifid_instr, ifid_imm, ifid_pc;

    logic [7:0] imem [256];

    typedef struct {
        string      name;
        logic [7:0] pc;
        logic       v;
        logic [7:0] instr;
        logic [7:0] imm;
        logic [7:0] ipc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    fetch_stage #(.AW(8), .DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_en      (pc_en),
        .pc_load    (pc_load),
        .pc_src     (pc_src),
        .addr_src   (addr_src),
        .stall      (stall),
        .r_rb_ex    (r_rb_ex),
        .r_rb_d     (r_rb_d),
        .stack_data (stack_data),
        .imem_rdata (imem_rdata),
        .imem_addr  (imem_addr),
        .pc         (pc),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_imm   (ifid_imm),
        .ifid_pc    (ifid_pc)
    );

    assign imem_rdata = imem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs for the next rising edge and queue the state expected after it
    task automatic drive(input string name, input logic en, input logic ld,
                         input logic [1:0] src, input logic [1:0] asrc, input logic st,
                         input logic [7:0] e_pc, input logic e_v, input logic [7:0] e_instr,
                         input logic [7:0] e_imm, input logic [7:0] e_ipc);
        exp_t e;
        pc_en    = en;
        pc_load  = ld;
        pc_src   = src;
        addr_src = asrc;
        stall    = st;
        e.name = name; e.pc = e_pc; e.v = e_v;
        e.instr = e_instr; e.imm = e_imm; e.ipc = e_ipc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: compare the DUT state after each edge with the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".pc"},         32'(pc),         32'(e.pc));
                chk({e.name, ".ifid_valid"}, 32'(ifid_valid), 32'(e.v));
                chk({e.name, ".ifid_instr"}, 32'(ifid_instr), 32'(e.instr));
                chk({e.name, ".ifid_imm"},   32'(ifid_imm),   32'(e.imm));
                chk({e.name, ".ifid_pc"},    32'(ifid_pc),    32'(e.ipc));
            end
        end
    end

    initial begin
        #100000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[8'h00] = 8'h20;
        imem[8'h01] = 8'hC9;
        imem[8'h02] = 8'h12;
        imem[8'h03] = 8'hCA;
        imem[8'h20] = 8'h11;
        imem[8'h21] = 8'h22;
        imem[8'h22] = 8'h33;
        imem[8'h30] = 8'hC5;
        imem[8'h31] = 8'h7E;
        imem[8'h32] = 8'hC1;
        imem[8'h40] = 8'h55;
        imem[8'hFE] = 8'h66;

        reset      = 1'b0;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        pc_src     = 2'b00;
        addr_src   = 2'b00;
        stall      = 1'b0;
        r_rb_ex    = 8'h40;
        r_rb_d     = 8'h30;
        stack_data = 8'hFE;

        #2;
        chk("reset.pc",         32'(pc),         32'h0);
        chk("reset.ifid_valid", 32'(ifid_valid), 32'h0);
        chk("reset.ifid_instr", 32'(ifid_instr), 32'h0);
        chk("reset.ifid_imm",   32'(ifid_imm),   32'h0);
        chk("reset.ifid_pc",    32'(ifid_pc),    32'h0);

        @(negedge clk);
        reset = 1'b1;

        // Reset vector: load PC from imem[0] while addressing slot 0
        drive("rst_vec", 1, 1, 2'b01, 2'b01, 0, 8'h20, 0, 8'h00, 8'h00, 8'h00);
        #1 chk("rst_vec.imem_addr", 32'(imem_addr), 32'h00);
        tick();

        // One-byte stream (addr_src 11 also selects PC)
        drive("s1", 1, 0, 2'b00, 2'b00, 0, 8'h21, 1, 8'h11, 8'h00, 8'h20);
        #1 chk("s1.imem_addr", 32'(imem_addr), 32'h20);
        tick();
        drive("s2", 1, 0, 2'b00, 2'b11, 0, 8'h22, 1, 8'h22, 8'h00, 8'h21);
        tick();
        drive("s3", 1, 0, 2'b00, 2'b00, 0, 8'h23, 1, 8'h33, 8'h00, 8'h22);
        tick();

        // Jump to 0x30: flush keeps ifid payload, drops valid
        drive("jmp30", 1, 1, 2'b10, 2'b00, 0, 8'h30, 0, 8'h33, 8'h00, 8'h22);
        tick();

        // Two-byte instruction C5 7E
        drive("wide1", 1, 0, 2'b00, 2'b00, 0, 8'h31, 0, 8'hC5, 8'h00, 8'h30);
        tick();
        drive("wide2", 1, 0, 2'b00, 2'b00, 0, 8'h32, 1, 8'hC5, 8'h7E, 8'h30);
        tick();

        // Enter F_IMM, then flush with stall in the same cycle
        drive("op_c1", 1, 0, 2'b00, 2'b00, 0, 8'h33, 0, 8'hC1, 8'h00, 8'h32);
        tick();
        drive("flush_stall", 1, 1, 2'b00, 2'b00, 1, 8'h40, 0, 8'hC1, 8'h00, 8'h32);
        tick();
        // Byte at 0x40 must be taken as an opcode
        drive("after_flush", 1, 0, 2'b00, 2'b00, 0, 8'h41, 1, 8'h55, 8'h00, 8'h40);
        tick();
        drive("stall_hold", 0, 0, 2'b00, 2'b00, 1, 8'h41, 1, 8'h55, 8'h00, 8'h40);
        tick();

        // PC wrap while stalled
        drive("ld_fe", 1, 1, 2'b11, 2'b00, 0, 8'hFE, 0, 8'h55, 8'h00, 8'h40);
        tick();
        drive("cap_fe", 1, 0, 2'b00, 2'b00, 0, 8'hFF, 1, 8'h66, 8'h00, 8'hFE);
        tick();
        drive("wrap1", 1, 0, 2'b00, 2'b00, 1, 8'h00, 1, 8'h66, 8'h00, 8'hFE);
        tick();
        drive("wrap2", 1, 0, 2'b00, 2'b00, 1, 8'h01, 1, 8'h66, 8'h00, 8'hFE);
        tick();

        // Interrupt-vector read while in F_IMM returns FSM to F_OP
        drive("cap_01", 1, 0, 2'b00, 2'b00, 0, 8'h02, 0, 8'hC9, 8'h00, 8'h01);
        tick();
        drive("int_vec", 0, 0, 2'b00, 2'b10, 0, 8'h02, 0, 8'hC9, 8'h00, 8'h01);
        #1 chk("int_vec.imem_addr", 32'(imem_addr), 32'h01);
        tick();
        drive("cap_02", 1, 0, 2'b00, 2'b00, 0, 8'h03, 1, 8'h12, 8'h00, 8'h02);
        tick();

        // Async reset in the middle of a two-byte fetch
        drive("cap_03", 1, 0, 2'b00, 2'b00, 0, 8'h04, 0, 8'hCA, 8'h00, 8'h03);
        tick();
        pc_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("areset.pc",         32'(pc),         32'h0);
        chk("areset.ifid_valid", 32'(ifid_valid), 32'h0);
        chk("areset.ifid_instr", 32'(ifid_instr), 32'h0);
        chk("areset.ifid_imm",   32'(ifid_imm),   32'h0);
        chk("areset.ifid_pc",    32'(ifid_pc),    32'h0);
        #1 reset = 1'b1;
        drive("post_reset", 1, 0, 2'b00, 2'b00, 0, 8'h01, 1, 8'h20, 8'h00, 8'h00);
        tick();

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter AW, default 8, instruction-memory address width and PC width.
REQ-002 Parameter DW, default 8, instruction byte width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pc_en  input  1  PC update enable from PC control unit.
REQ-006 pc_load  input  1  with pc_en, load PC from source selected by pc_src; else increment.
REQ-007 pc_src  input  2  00 r_rb_ex, 01 imem_rdata (vector), 10 r_rb_d, 11 stack_data.
REQ-008 addr_src  input  2  00 PC, 01 address 0 (reset vector), 10 address 1 (interrupt vector), 11 PC.
REQ-009 stall  input  1  freeze fetch register and FSM.
REQ-010 r_rb_ex / r_rb_d / stack_data  input  AW each  branch, jump and return targets.
REQ-011 imem_rdata  input  DW  combinational instruction-memory read data for imem_addr.
REQ-012 imem_addr  output  AW  combinational instruction-memory address.
REQ-013 pc  output  AW  current PC register.
REQ-014 ifid_valid  output  1  IF/ID register holds a complete instruction.
REQ-015 ifid_instr / ifid_imm  output  DW each  opcode byte; second byte (0 for one-byte instructions).
REQ-016 ifid_pc  output  AW  address of the opcode byte held in ifid_instr.

Function
REQ-017 imem_addr SHALL be decoded from addr_src per REQ-008, combinationally, every cycle.
REQ-018 On a clock edge with pc_en=1, pc_load=1: pc SHALL take the pc_src-selected value.
REQ-019 On a clock edge with pc_en=1, pc_load=0: pc SHALL become pc+1 modulo 2^AW (8'hFF -> 8'h00).
REQ-020 With pc_en=0, pc SHALL hold; pc is unaffected by stall.
REQ-021 FSM states: F_OP (expect opcode byte), F_IMM (expect second byte); reset state F_OP.
REQ-022 A capture cycle SHALL be any edge with stall=0, addr_src=00 or 11, and no flush.
REQ-023 F_OP capture: ifid_instr<=imem_rdata, ifid_pc<=pc, ifid_imm<=0.
REQ-024 In the same F_OP capture, if imem_rdata[DW-1:DW-4]==4'd12: ifid_valid<=0, go to F_IMM.
REQ-025 In the same F_OP capture, otherwise: ifid_valid<=1, stay in F_OP.
REQ-026 F_IMM capture: ifid_imm<=imem_rdata, ifid_valid<=1, return to F_OP; ifid_instr/ifid_pc hold.
REQ-027 Flush = pc_en&pc_load: ifid_valid<=0, FSM->F_OP, ifid_instr/imm/pc hold.
REQ-028 Flush SHALL take priority over stall and over capture in the same cycle.
REQ-029 stall=1 without flush: FSM, ifid_* all hold.
REQ-030 addr_src=01/10 without flush or stall: ifid_valid<=0, FSM->F_OP (vector fetch is never an instruction).
REQ-031 A new F_OP capture SHALL overwrite a prior valid entry; no downstream handshake beyond stall.

Reset
REQ-032 reset=0 SHALL immediately, regardless of clk: pc=0, ifid_valid=0, ifid_instr=0, ifid_imm=0, ifid_pc=0, FSM=F_OP.
REQ-033 Reset asserted mid two-byte fetch SHALL discard the partial instruction; first post-reset capture treated as opcode.
REQ-034 Release of reset SHALL take effect on the next rising edge with no extra latency.

Verification
REQ-035 Reset vector: reset released, addr_src=01, pc_en=1, pc_load=1, pc_src=01, imem[0]=8'h20 -> imem_addr=0, pc=8'h20 after one edge, ifid_valid=0.
REQ-036 One-byte stream: pc=8'h20, pc_en=1, pc_load=0, imem[20..22]=8'h11,8'h22,8'h33 -> ifid_instr 11/22/33 on successive edges, ifid_pc 20/21/22, ifid_valid=1, ifid_imm=0.
REQ-037 Two-byte: imem[30]=8'hC5, imem[31]=8'h7E -> edge1 ifid_valid=0, edge2 ifid_valid=1, ifid_instr=C5, ifid_imm=7E, ifid_pc=30.
REQ-038 Flush vs stall: pc_load=1, pc_en=1, pc_src=00, r_rb_ex=8'h40, stall=1 same cycle -> pc=40, ifid_valid=0, FSM=F_OP.
REQ-039 Wrap and stall: pc=8'hFF, pc_en=1, stall=1 for 2 cycles -> pc=00 then 01, ifid_* unchanged.
REQ-040 Async reset: reset=0 pulse between edges while in F_IMM -> all outputs zero before next edge; next opcode captured normally.
